// File: rtl/keypad_scan_db.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_db
// Description : Debounced keypad scanner. Accepts a stable one-hot key
//               pattern and emits a one-cycle strobe plus key code. It can
//               also emit auto-repeat strobes while a single key is held.
//               Patterns with several keys down raise a one-cycle error
//               strobe instead of a key strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_db #(
    parameter int  NUM_KEYS        = 3,
    parameter int  DEBOUNCE_CYCLES = 4,
    parameter int  REPEAT_DELAY    = 16,
    parameter int  REPEAT_RATE     = 8,
    localparam int CODE_W          = $clog2(NUM_KEYS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                repeat_en,
    input  logic [NUM_KEYS-1:0] keypad_in,
    output logic [NUM_KEYS-1:0] scan_out,
    output logic                key_valid,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_held,
    output logic                multi_err
);

    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_DB_FULL   = c_CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DB_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_RPT_W-1:0] c_RPT_FIRST = c_RPT_W'(REPEAT_DELAY);
    localparam logic [c_RPT_W-1:0] c_RPT_NEXT  = c_RPT_W'(REPEAT_RATE);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t                state_q,     state_d;
    logic [NUM_KEYS-1:0]   pat_q,       pat_d;
    logic [c_CNT_W-1:0]    cnt_q,       cnt_d;
    logic [c_RPT_W-1:0]    rpt_q,       rpt_d;
    // 1 while waiting for the first (long) repeat interval, 0 for later ones
    logic                  rpt_first_q, rpt_first_d;
    logic [NUM_KEYS-1:0]   scan_q,      scan_d;
    logic                  valid_q,     valid_d;
    logic [CODE_W-1:0]     code_q,      code_d;
    logic                  held_q,      held_d;
    logic                  merr_q,      merr_d;

    logic                  w_pat_any;
    logic                  w_pat_many;
    logic [CODE_W-1:0]     w_pat_code;
    logic [c_RPT_W-1:0]    w_rpt_inc;
    logic [c_RPT_W-1:0]    w_rpt_target;

    // Classify the latched pattern: empty, single key (with its code) or multi-key
    always_comb begin
        w_pat_any  = 1'b0;
        w_pat_many = 1'b0;
        w_pat_code = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (pat_q[i]) begin
                if (w_pat_any) begin
                    w_pat_many = 1'b1;
                end
                w_pat_any  = 1'b1;
                w_pat_code = CODE_W'(i + 1);
            end
        end
    end

    assign w_rpt_inc    = rpt_q + 1'b1;
    assign w_rpt_target = rpt_first_q ? c_RPT_FIRST : c_RPT_NEXT;

    // Next-state and next-output computation for the debounce/hold/release FSM
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        cnt_d       = cnt_q;
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
        scan_d      = '0;
        valid_d     = 1'b0;
        code_d      = code_q;
        held_d      = held_q;
        merr_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (keypad_in != '0) begin
                    pat_d   = keypad_in;
                    cnt_d   = c_CNT_W'(1);
                    state_d = S_DEBOUNCE;
                end
            end

            S_DEBOUNCE: begin
                if (keypad_in == '0) begin
                    pat_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (keypad_in != pat_q) begin
                    // Pattern moved under us: restart the stability count
                    pat_d = keypad_in;
                    cnt_d = c_CNT_W'(1);
                end else if (cnt_q < c_DB_FULL) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d     = S_HELD;
                    cnt_d       = '0;
                    rpt_d       = '0;
                    rpt_first_d = 1'b1;
                    if (w_pat_many) begin
                        merr_d = 1'b1;
                        code_d = '0;
                        held_d = 1'b0;
                    end else begin
                        scan_d  = pat_q;
                        valid_d = 1'b1;
                        code_d  = w_pat_code;
                        held_d  = 1'b1;
                    end
                end
            end

            S_HELD: begin
                if (keypad_in != pat_q) begin
                    // Any change (release, extra key, different key) waits for a clean release
                    state_d     = S_RELEASE;
                    cnt_d       = '0;
                    rpt_d       = '0;
                    rpt_first_d = 1'b1;
                end else if (held_q && repeat_en) begin
                    if (w_rpt_inc == w_rpt_target) begin
                        scan_d      = pat_q;
                        valid_d     = 1'b1;
                        rpt_d       = '0;
                        rpt_first_d = 1'b0;
                    end else begin
                        rpt_d = w_rpt_inc;
                    end
                end else begin
                    // Repeat disabled or multi-key hold: re-arm the long first delay
                    rpt_d       = '0;
                    rpt_first_d = 1'b1;
                end
            end

            S_RELEASE: begin
                if (keypad_in == '0) begin
                    if (cnt_q == c_DB_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        pat_d   = '0;
                        held_d  = 1'b0;
                        code_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
            cnt_q       <= '0;
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
            scan_q      <= '0;
            valid_q     <= 1'b0;
            code_q      <= '0;
            held_q      <= 1'b0;
            merr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            cnt_q       <= cnt_d;
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
            scan_q      <= scan_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            held_q      <= held_d;
            merr_q      <= merr_d;
        end
    end

    assign scan_out  = scan_q;
    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_held  = held_q;
    assign multi_err = merr_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_db.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_db
// Description : Self-checking bench for keypad_scan_db with directed
//               scenarios and randomized stimulus against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_db;

    localparam int NK = 3;
    localparam int DB = 4;
    localparam int RD = 16;
    localparam int RR = 8;
    localparam int CW = 2;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_HELD = 2;
    localparam int P_REL  = 3;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          repeat_en = 1'b0;
    logic [NK-1:0] keypad_in = '0;
    logic [NK-1:0] scan_out;
    logic          key_valid;
    logic [CW-1:0] key_code;
    logic          key_held;
    logic          multi_err;
    logic [7:0]    obs_vec;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: phase, stable-run length, zero-run length,
    // repeat origin edge (-1 = not counting) and an edge counter
    int            m_phase  = P_IDLE;
    int            m_run    = 0;
    int            m_zrun   = 0;
    int            m_origin = -1;
    int            m_t      = 0;
    logic [NK-1:0] m_pat    = '0;
    logic [NK-1:0] exp_scan  = '0;
    logic          exp_valid = 1'b0;
    logic [CW-1:0] exp_code  = '0;
    logic          exp_held  = 1'b0;
    logic          exp_merr  = 1'b0;

    keypad_scan_db #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .repeat_en(repeat_en),
        .keypad_in(keypad_in),
        .scan_out (scan_out),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_held (key_held),
        .multi_err(multi_err)
    );

    assign obs_vec = {scan_out, key_valid, key_code, key_held, multi_err};

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_vec();
        return {exp_scan, exp_valid, exp_code, exp_held, exp_merr};
    endfunction

    // Behavioural model: applies one sampled edge of inputs
    task automatic model_edge(input logic [NK-1:0] k, input logic r, input logic ren);
        int d;
        int idx;
        m_t++;
        exp_scan  = '0;
        exp_valid = 1'b0;
        exp_merr  = 1'b0;
        if (r) begin
            m_phase  = P_IDLE;
            m_origin = -1;
            exp_code = '0;
            exp_held = 1'b0;
            return;
        end
        case (m_phase)
            P_IDLE: begin
                if (k != 0) begin
                    m_pat   = k;
                    m_run   = 1;
                    m_phase = P_WAIT;
                end
            end
            P_WAIT: begin
                if (k == 0) begin
                    m_phase = P_IDLE;
                end else if (k != m_pat) begin
                    m_pat = k;
                    m_run = 1;
                end else begin
                    m_run++;
                    if (m_run == DB + 1) begin
                        m_phase  = P_HELD;
                        m_origin = m_t;
                        if ($countones(m_pat) == 1) begin
                            idx = 0;
                            while (!m_pat[idx]) idx++;
                            exp_scan  = m_pat;
                            exp_valid = 1'b1;
                            exp_code  = CW'(idx + 1);
                            exp_held  = 1'b1;
                        end else begin
                            exp_merr = 1'b1;
                            exp_code = '0;
                            exp_held = 1'b0;
                        end
                    end
                end
            end
            P_HELD: begin
                if (k != m_pat) begin
                    m_phase  = P_REL;
                    m_zrun   = 0;
                    m_origin = -1;
                end else if (exp_held) begin
                    if (!ren) begin
                        m_origin = -1;
                    end else begin
                        if (m_origin < 0) m_origin = m_t - 1;
                        d = m_t - m_origin;
                        if (d == RD || (d > RD && (d - RD) % RR == 0)) begin
                            exp_scan  = m_pat;
                            exp_valid = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (k == 0) begin
                    m_zrun++;
                    if (m_zrun == DB) begin
                        m_phase  = P_IDLE;
                        exp_held = 1'b0;
                        exp_code = '0;
                    end
                end else begin
                    m_zrun = 0;
                end
            end
        endcase
    endtask

    // Drive one cycle of inputs, advance the model, settle past the edge
    task automatic step(input logic [NK-1:0] k, input logic r, input logic ren);
        keypad_in = k;
        rst       = r;
        repeat_en = ren;
        @(posedge clk);
        model_edge(k, r, ren);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step('0, 1'b1, 1'b0);
            n_checks++;
            if (obs_vec !== 8'h00) begin
                n_errors++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", i, obs_vec, 8'h00);
            end
        end
        step('0, 1'b0, 1'b0);
        n_checks++;
        if (obs_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL reset_idle got=%b exp=%b", obs_vec, exp_vec());
        end
    endtask

    task automatic test_single_press();
        int            nv = 0;
        int            at = -1;
        logic [CW-1:0] code_at = '0;
        logic [NK-1:0] scan_at = '0;
        for (int i = 0; i < 10; i++) begin
            step(3'b010, 1'b0, 1'b0);
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL press_model cyc=%0d got=%b exp=%b", i, obs_vec, exp_vec());
            end
            if (key_valid === 1'b1) begin
                nv++;
                at      = i;
                code_at = key_code;
                scan_at = scan_out;
            end
        end
        n_checks++;
        if (nv !== 1 || at !== 4) begin
            n_errors++;
            $display("FAIL press_latency got count=%0d at=%0d exp count=1 at=4", nv, at);
        end
        n_checks++;
        if (code_at !== 2'd2 || scan_at !== 3'b010) begin
            n_errors++;
            $display("FAIL press_code got code=%0d scan=%b exp code=2 scan=010", code_at, scan_at);
        end
        for (int i = 0; i < 6; i++) begin
            step('0, 1'b0, 1'b0);
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL release_model cyc=%0d got=%b exp=%b", i, obs_vec, exp_vec());
            end
            if (i == 3) begin
                n_checks++;
                if (key_held !== 1'b1 || key_code !== 2'd2) begin
                    n_errors++;
                    $display("FAIL release_hold got held=%b code=%0d exp held=1 code=2", key_held, key_code);
                end
            end
            if (i == 4) begin
                n_checks++;
                if (key_held !== 1'b0 || key_code !== 2'd0) begin
                    n_errors++;
                    $display("FAIL release_done got held=%b code=%0d exp held=0 code=0", key_held, key_code);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [NK-1:0] seq_q[$];
        int            nv = 0;
        int            at = -1;
        seq_q = '{3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b001,
                  3'b001, 3'b001, 3'b001,
                  3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        foreach (seq_q[i]) begin
            step(seq_q[i], 1'b0, 1'b0);
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL bounce_model cyc=%0d got=%b exp=%b", i, obs_vec, exp_vec());
            end
            if (key_valid === 1'b1) begin
                nv++;
                at = i;
            end
        end
        n_checks++;
        if (nv !== 1 || at !== 9) begin
            n_errors++;
            $display("FAIL bounce_strobe got count=%0d at=%0d exp count=1 at=9", nv, at);
        end
        n_checks++;
        if (key_held !== 1'b0) begin
            n_errors++;
            $display("FAIL bounce_release got held=%b exp held=0", key_held);
        end
    endtask

    task automatic test_multi_key();
        int nm = 0;
        int nv = 0;
        for (int i = 0; i < 12; i++) begin
            step((i < 6) ? 3'b101 : 3'b000, 1'b0, 1'b1);
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL multi_model cyc=%0d got=%b exp=%b", i, obs_vec, exp_vec());
            end
            if (multi_err === 1'b1) nm++;
            if (key_valid === 1'b1 || key_held === 1'b1 || key_code !== 2'd0) nv++;
        end
        n_checks++;
        if (nm !== 1 || nv !== 0) begin
            n_errors++;
            $display("FAIL multi_err got errs=%0d key_activity=%0d exp errs=1 key_activity=0", nm, nv);
        end
    endtask

    task automatic test_auto_repeat();
        int exp_at[6] = '{4, 20, 28, 36, 44, 52};
        int got_q[$];
        int nv;
        for (int pass = 0; pass < 2; pass++) begin
            got_q.delete();
            nv = 0;
            for (int i = 0; i < 66; i++) begin
                step((i < 60) ? 3'b100 : 3'b000, 1'b0, (pass == 0));
                n_checks++;
                if (obs_vec !== exp_vec()) begin
                    n_errors++;
                    $display("FAIL repeat_model pass=%0d cyc=%0d got=%b exp=%b", pass, i, obs_vec, exp_vec());
                end
                if (key_valid === 1'b1) begin
                    nv++;
                    got_q.push_back(i);
                    n_checks++;
                    if (key_code !== 2'd3 || scan_out !== 3'b100) begin
                        n_errors++;
                        $display("FAIL repeat_code cyc=%0d got code=%0d scan=%b exp code=3 scan=100", i, key_code, scan_out);
                    end
                end
            end
            n_checks++;
            if (nv !== ((pass == 0) ? 6 : 1)) begin
                n_errors++;
                $display("FAIL repeat_count pass=%0d got=%0d exp=%0d", pass, nv, (pass == 0) ? 6 : 1);
            end
            for (int j = 0; j < got_q.size() && j < 6; j++) begin
                n_checks++;
                if (got_q[j] !== exp_at[j]) begin
                    n_errors++;
                    $display("FAIL repeat_time pass=%0d idx=%0d got=%0d exp=%0d", pass, j, got_q[j], exp_at[j]);
                end
            end
        end
    endtask

    task automatic test_key_change();
        logic [NK-1:0] seq_q[$];
        int            nv = 0;
        seq_q = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
                  3'b011, 3'b011, 3'b011, 3'b011, 3'b011,
                  3'b000, 3'b000, 3'b000, 3'b000};
        foreach (seq_q[i]) begin
            step(seq_q[i], 1'b0, 1'b0);
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL change_model cyc=%0d got=%b exp=%b", i, obs_vec, exp_vec());
            end
            if (key_valid === 1'b1 && i > 4) nv++;
            if (i >= 6 && i <= 13) begin
                n_checks++;
                if (key_held !== 1'b1 || key_code !== 2'd1) begin
                    n_errors++;
                    $display("FAIL change_hold cyc=%0d got held=%b code=%0d exp held=1 code=1", i, key_held, key_code);
                end
            end
        end
        n_checks++;
        if (nv !== 0 || key_held !== 1'b0) begin
            n_errors++;
            $display("FAIL change_release got extra=%0d held=%b exp extra=0 held=0", nv, key_held);
        end
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            step((i < 6) ? 3'b010 : 3'b000, 1'b0, 1'b0);
            if (key_valid === 1'b1) begin
                nv++;
                n_checks++;
                if (i !== 4 || key_code !== 2'd2) begin
                    n_errors++;
                    $display("FAIL change_newkey got at=%0d code=%0d exp at=4 code=2", i, key_code);
                end
            end
        end
        n_checks++;
        if (nv !== 1) begin
            n_errors++;
            $display("FAIL change_newkey_count got=%0d exp=1", nv);
        end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        int at = -1;
        // Reset during DEBOUNCE, key held across deassertion
        step(3'b001, 1'b0, 1'b0);
        step(3'b001, 1'b0, 1'b0);
        step(3'b001, 1'b1, 1'b0);
        n_checks++;
        if (obs_vec !== 8'h00) begin
            n_errors++;
            $display("FAIL rst_debounce got=%b exp=%b", obs_vec, 8'h00);
        end
        for (int i = 0; i < 6; i++) begin
            step(3'b001, 1'b0, 1'b0);
            if (key_valid === 1'b1) begin
                nv++;
                at = i;
            end
        end
        n_checks++;
        if (nv !== 1 || at !== 4) begin
            n_errors++;
            $display("FAIL rst_reaccept got count=%0d at=%0d exp count=1 at=4", nv, at);
        end
        // Reset during HELD
        step('0, 1'b1, 1'b0);
        n_checks++;
        if (obs_vec !== 8'h00) begin
            n_errors++;
            $display("FAIL rst_held got=%b exp=%b", obs_vec, 8'h00);
        end
        // Reset during RELEASE
        for (int i = 0; i < 8; i++) step((i < 6) ? 3'b010 : 3'b000, 1'b0, 1'b0);
        n_checks++;
        if (key_held !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_pre_release got held=%b exp held=1", key_held);
        end
        step('0, 1'b1, 1'b0);
        n_checks++;
        if (obs_vec !== 8'h00) begin
            n_errors++;
            $display("FAIL rst_release got=%b exp=%b", obs_vec, 8'h00);
        end
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            step('0, 1'b0, 1'b0);
            if (obs_vec !== 8'h00) nv++;
        end
        n_checks++;
        if (nv !== 0 || obs_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL rst_quiet got active=%0d vec=%b exp active=0 vec=%b", nv, obs_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [NK-1:0] k;
        logic [NK-1:0] prev;
        logic          ren;
        logic          r;
        int            len;
        int            sel;
        prev = '0;
        for (int ep = 0; ep < 60; ep++) begin
            ren = 1'($urandom_range(0, 1));
            for (int seg = 0; seg < 6; seg++) begin
                sel = $urandom_range(0, 9);
                if (sel < 4) begin
                    k = '0;
                end else if (sel < 8) begin
                    k = NK'(1) << $urandom_range(0, NK - 1);
                end else if (sel == 8) begin
                    do k = NK'($urandom_range(1, 7)); while ($countones(k) < 2);
                end else begin
                    k = prev;
                end
                prev = k;
                len  = $urandom_range(1, DB + 30);
                for (int c = 0; c < len; c++) begin
                    r = ($urandom_range(0, 79) == 0);
                    step(k, r, ren);
                    n_checks++;
                    if (obs_vec !== exp_vec()) begin
                        n_errors++;
                        $display("FAIL random ep=%0d seg=%0d cyc=%0d in=%b rst=%b ren=%b got=%b exp=%b",
                                 ep, seg, c, k, r, ren, obs_vec, exp_vec());
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_auto_repeat();
        test_key_change();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
